full_adder_unit: RTL and testbench

Registered ripple-carry adder. Adds two WIDTH-bit operands and a carry-in, and produces the sum, carry-out and signed-overflow flag one clock after the operands are accepted. With default parameters it acts as the single-bit adder cell used by the small arithmetic datapaths: inputs A, B, outputs Sum, Cout. A valid strobe travels alongside the data so that downstream logic knows which results are meaningful.

---
 rtl/full_adder_unit.sv | 63 ++++++
 tb/tb_full_adder_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/full_adder_unit.sv
// Registered ripple-carry adder: a chain of full-adder cells feeding one output register stage.
// Sum/Cout/Ovf only load when a valid operation is accepted, and otherwise hold their value.

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;

  assign carry[0] = Cin;

  fa_cell u_cell [WIDTH-1:0] (
    .a  (A),
    .b  (B),
    .ci (carry[WIDTH-1:0]),
    .s  (sum_c),
    .co (carry[WIDTH:1])
  );

  // Signed overflow: like-signed operands whose sum flips sign.
  assign ovf_c = (A[MSB] == B[MSB]) && (sum_c[MSB] != A[MSB]);

  always_ff @(posedge clk) begin
    if (rst) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= sum_c;
        Cout <= carry[WIDTH];
        Ovf  <= ovf_c;
      end
    end
  end
endmodule

// File: tb/tb_full_adder_unit.sv
// Bench for full_adder_unit: a 1-bit and an 8-bit instance driven in lockstep, checked against
// an integer-arithmetic reference model one cycle after each edge.

module tb_full_adder_unit;
  logic clk = 1'b0;
  logic rst;

  logic       v1, a1, b1, c1;
  logic       s1, co1, ov1, ov1_vld;
  logic       v8, c8;
  logic [7:0] a8, b8, s8;
  logic       co8, ov8, vld8;

  int checks   = 0;
  int failures = 0;

  // reference state
  longint m1_sum, m1_cout, m1_ovf, m1_vld;
  longint m8_sum, m8_cout, m8_ovf, m8_vld;

  always #5 clk = ~clk;

  full_adder_unit #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Cin(c1),
    .Sum(s1), .Cout(co1), .Ovf(ov1), .out_valid(ov1_vld)
  );

  full_adder_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .Cin(c8),
    .Sum(s8), .Cout(co8), .Ovf(ov8), .out_valid(vld8)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain arithmetic: unsigned add for Sum/Cout, signed range test for Ovf.
  task automatic model(input int w, input longint a, input longint b, input longint c,
                       output longint sum, output longint cout, output longint ovf);
    longint full, sa, sb, sv, lim;
    lim  = longint'(1) << (w - 1);
    full = a + b + c;
    sum  = full % (longint'(1) << w);
    cout = full >> w;
    sa   = (a >= lim) ? a - 2 * lim : a;
    sb   = (b >= lim) ? b - 2 * lim : b;
    sv   = sa + sb + c;
    ovf  = (sv < -lim || sv > lim - 1) ? 1 : 0;
  endtask

  task automatic update(input logic r);
    longint s, co, ov;
    if (r) begin
      m1_sum = 0; m1_cout = 0; m1_ovf = 0; m1_vld = 0;
      m8_sum = 0; m8_cout = 0; m8_ovf = 0; m8_vld = 0;
    end else begin
      m1_vld = v1;
      if (v1) begin
        model(1, longint'(a1), longint'(b1), longint'(c1), s, co, ov);
        m1_sum = s; m1_cout = co; m1_ovf = ov;
      end
      m8_vld = v8;
      if (v8) begin
        model(8, longint'(a8), longint'(b8), longint'(c8), s, co, ov);
        m8_sum = s; m8_cout = co; m8_ovf = ov;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sum1"},  longint'(s1),      m1_sum);
    chk({tag, ".cout1"}, longint'(co1),     m1_cout);
    chk({tag, ".ovf1"},  longint'(ov1),     m1_ovf);
    chk({tag, ".vld1"},  longint'(ov1_vld), m1_vld);
    chk({tag, ".sum8"},  longint'(s8),      m8_sum);
    chk({tag, ".cout8"}, longint'(co8),     m8_cout);
    chk({tag, ".ovf8"},  longint'(ov8),     m8_ovf);
    chk({tag, ".vld8"},  longint'(vld8),    m8_vld);
  endtask

  // Drive both instances, take one edge, advance the model and compare.
  task automatic cyc(input string tag, input logic r,
                     input logic iv1, input logic ia1, input logic ib1, input logic ic1,
                     input logic iv8, input logic [7:0] ia8, input logic [7:0] ib8, input logic ic8);
    rst = r;
    v1 = iv1; a1 = ia1; b1 = ib1; c1 = ic1;
    v8 = iv8; a8 = ia8; b8 = ib8; c8 = ic8;
    @(posedge clk);
    #1;
    update(r);
    check_all(tag);
  endtask

  initial begin
    logic [1:0] hv;
    rst = 1'b1; v1 = 0; a1 = 0; b1 = 0; c1 = 0; v8 = 0; a8 = 0; b8 = 0; c8 = 0;

    // reset with live valid operands
    cyc("rst0", 1, 1, 1, 1, 0, 1, 8'h01, 8'h01, 0);
    cyc("rst1", 1, 1, 1, 1, 0, 1, 8'h01, 8'h01, 0);
    chk("rst.sum8_zero", longint'(s8), 0);
    chk("rst.vld8_zero", longint'(vld8), 0);

    // half-adder truth table
    for (int i = 0; i < 4; i++) begin
      hv = i[1:0];
      cyc("ha", 0, 1, hv[1], hv[0], 0, 0, 8'h00, 8'h00, 0);
      chk("ha.sum_xor", longint'(s1), longint'(hv[1] ^ hv[0]));
      chk("ha.cout_and", longint'(co1), longint'(hv[1] & hv[0]));
    end

    // full-adder with carry-in
    cyc("fa11", 0, 1, 1, 1, 1, 0, 8'h00, 8'h00, 0);
    chk("fa11.sum", longint'(s1), 1);
    chk("fa11.cout", longint'(co1), 1);
    cyc("fa00", 0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 0);
    chk("fa00.sum", longint'(s1), 1);
    chk("fa00.cout", longint'(co1), 0);

    // hold: one valid op then three idle cycles with toggling operands
    cyc("hold_ld", 0, 1, 1, 0, 0, 1, 8'h12, 8'h34, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("hold", 0, 0, i[0], ~i[0], i[1], 0, 8'hA5 ^ 8'(i), 8'h5A, 1);
      chk("hold.sum1", longint'(s1), 1);
      chk("hold.cout1", longint'(co1), 0);
      chk("hold.vld1", longint'(ov1_vld), 0);
      chk("hold.sum8", longint'(s8), 'h46);
    end

    // 8-bit boundary cases
    cyc("w_ff01", 0, 0, 0, 0, 0, 1, 8'hFF, 8'h01, 0);
    chk("w_ff01.sum", longint'(s8), 'h00);
    chk("w_ff01.cout", longint'(co8), 1);
    chk("w_ff01.ovf", longint'(ov8), 0);
    cyc("w_7f01", 0, 0, 0, 0, 0, 1, 8'h7F, 8'h01, 0);
    chk("w_7f01.sum", longint'(s8), 'h80);
    chk("w_7f01.cout", longint'(co8), 0);
    chk("w_7f01.ovf", longint'(ov8), 1);
    cyc("w_8080", 0, 0, 0, 0, 0, 1, 8'h80, 8'h80, 0);
    chk("w_8080.sum", longint'(s8), 'h00);
    chk("w_8080.cout", longint'(co8), 1);
    chk("w_8080.ovf", longint'(ov8), 1);
    cyc("w_wrap", 0, 1, 1, 1, 1, 1, 8'hFF, 8'hFF, 1);
    chk("w_wrap.sum", longint'(s8), 'hFF);
    chk("w_wrap.cout", longint'(co8), 1);

    // reset mid-stream: op3 sampled under reset is discarded
    cyc("ms_op1", 0, 1, 1, 0, 0, 1, 8'h10, 8'h20, 0);
    cyc("ms_op2", 0, 1, 0, 1, 1, 1, 8'h33, 8'h44, 1);
    cyc("ms_op3", 1, 1, 1, 1, 1, 1, 8'h55, 8'h66, 0);
    chk("ms_op3.sum8", longint'(s8), 0);
    chk("ms_op3.vld8", longint'(vld8), 0);
    cyc("ms_op4", 0, 1, 1, 1, 0, 1, 8'h0F, 8'hF0, 1);
    chk("ms_op4.sum8", longint'(s8), 'h00);
    chk("ms_op4.cout8", longint'(co8), 1);
    chk("ms_op4.vld8", longint'(vld8), 1);

    // randomized traffic, occasional idle and reset cycles
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
